// File: rtl/tlb_lookup_arbiter.sv
// Arbitrates the single JTLB search port between I-side refill, D-side refill and CP0 TLBP,
// holding the key for a fixed latency and returning the sampled result with a one-cycle pulse.
module tlb_lookup_arbiter #(
  parameter int ENTRY_W    = 86,
  parameter int IDX_W      = 4,
  parameter int LOOKUP_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [7:0]         asid,
  input  logic               i_req,
  input  logic [18:0]        i_vpn2,
  output logic               i_resp,
  input  logic               d_req,
  input  logic [18:0]        d_vpn2,
  output logic               d_resp,
  input  logic               p_req,
  input  logic [18:0]        p_vpn2,
  output logic               p_resp,
  output logic [18:0]        tlb_s_vpn2,
  output logic [7:0]         tlb_s_asid,
  input  logic               tlb_s_found,
  input  logic [IDX_W-1:0]   tlb_s_index,
  input  logic [ENTRY_W-1:0] tlb_s_entry,
  output logic               resp_found,
  output logic [IDX_W-1:0]   resp_index,
  output logic [ENTRY_W-1:0] resp_entry,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D, OWN_P} owner_e;

  localparam logic [1:0] CNT_LAST = 2'(LOOKUP_LAT - 1);

  state_e             state_q;
  owner_e             owner_q;
  owner_e             owner_d;
  logic [1:0]         cnt_q;
  logic               rr_last_q;   // 1 = D was the last I/D grant
  logic               drop_q;
  logic [18:0]        key_vpn2_q;
  logic [7:0]         key_asid_q;
  logic [18:0]        sel_vpn2;
  logic               owner_req;
  logic               resp_ok;
  logic               resp_found_q;
  logic [IDX_W-1:0]   resp_index_q;
  logic [ENTRY_W-1:0] resp_entry_q;

  // Probe has absolute priority; I/D alternate only when both are pending.
  always_comb begin
    owner_d  = OWN_NONE;
    sel_vpn2 = '0;
    if (p_req) begin
      owner_d  = OWN_P;
      sel_vpn2 = p_vpn2;
    end else if (i_req && (!d_req || rr_last_q)) begin
      owner_d  = OWN_I;
      sel_vpn2 = i_vpn2;
    end else if (d_req) begin
      owner_d  = OWN_D;
      sel_vpn2 = d_vpn2;
    end
  end

  always_comb begin
    owner_req = 1'b0;
    case (owner_q)
      OWN_I:   owner_req = i_req;
      OWN_D:   owner_req = d_req;
      OWN_P:   owner_req = p_req;
      default: owner_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_NONE;
      cnt_q        <= '0;
      rr_last_q    <= 1'b1;
      drop_q       <= 1'b0;
      key_vpn2_q   <= '0;
      key_asid_q   <= '0;
      resp_found_q <= 1'b0;
      resp_index_q <= '0;
      resp_entry_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!flush && owner_d != OWN_NONE) begin
            key_vpn2_q <= sel_vpn2;
            key_asid_q <= asid;
            owner_q    <= owner_d;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
            state_q    <= S_LOOKUP;
            if (owner_d == OWN_I) rr_last_q <= 1'b0;
            else if (owner_d == OWN_D) rr_last_q <= 1'b1;
          end
        end
        S_LOOKUP: begin
          if (flush) begin
            state_q <= S_IDLE;
            owner_q <= OWN_NONE;
          end else begin
            if (!owner_req) drop_q <= 1'b1;
            if (cnt_q == CNT_LAST) begin
              resp_found_q <= tlb_s_found;
              resp_index_q <= tlb_s_index;
              resp_entry_q <= tlb_s_entry;
              state_q      <= S_RESP;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          owner_q <= OWN_NONE;
        end
        default: begin
          state_q <= S_IDLE;
          owner_q <= OWN_NONE;
        end
      endcase
    end
  end

  // A response is withheld if the owner let go of its request at any point.
  assign resp_ok    = (state_q == S_RESP) && owner_req && !drop_q;
  assign i_resp     = resp_ok && (owner_q == OWN_I);
  assign d_resp     = resp_ok && (owner_q == OWN_D);
  assign p_resp     = resp_ok && (owner_q == OWN_P);

  assign tlb_s_vpn2 = key_vpn2_q;
  assign tlb_s_asid = key_asid_q;
  assign resp_found = resp_found_q;
  assign resp_index = resp_index_q;
  assign resp_entry = resp_entry_q;
  assign busy       = (state_q != S_IDLE);

endmodule
